// File: rtl/vga_h_timing_counter.sv
// ---------------------------------------------------------------------------
// vga_h_timing_counter
//
// Free-running horizontal pixel counter for the SVGA 800x600@60 Hz timing
// chain. It runs on the 40 MHz pixel clock and counts 0..H_TOTAL-1, which is
// one scan line. It also decodes the line-level flags that drive the vertical
// counter and the pixel pipeline.
//
// Ports
//   clk     in   1      pixel clock; all logic on the rising edge
//   rst     in   1      synchronous, active-high reset (count -> 0)
//   count   out  CNT_W  current horizontal position, 0..H_TOTAL-1
//   eol     out  1      high while count == H_TOTAL-1
//   active  out  1      high while count < H_ACTIVE
//   hsync   out  1      SYNC_POL inside the sync pulse, ~SYNC_POL elsewhere
//
// Parameters
//   CNT_W must satisfy 2**CNT_W >= H_TOTAL.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module vga_h_timing_counter #(
   parameter int CNT_W    = 11,
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BP     = 88,
   parameter bit SYNC_POL = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] count,
   output logic             eol,
   output logic             active,
   output logic             hsync
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;

   // Decode boundaries, pre-sized to the counter width so every compare
   // below is between equal-width operands.
   localparam logic [CNT_W-1:0] LAST_POS   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] ACTIVE_END = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);

   // The declaration value is the power-up contents of the flop, so count
   // reads 0 (never X) before the first clock edge or reset.
   logic [CNT_W-1:0] count_reg = '0;
   logic [CNT_W-1:0] count_next;

   // Wrap on the last position of the line; any out-of-range value (which
   // can only arise from an upset) is treated the same way, so the counter
   // always recovers to 0 on the next edge.
   always_comb begin
      count_next = count_reg + 1'b1;
      if (count_reg >= LAST_POS) begin
         count_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   // Flags are decoded straight from the registered count, so they carry no
   // extra latency. Each is a compare against a constant fed only by
   // count_reg, so it changes once per clock right after the edge.
   logic in_sync;

   always_comb begin
      in_sync = (count_reg >= SYNC_START) && (count_reg < SYNC_END);
      eol     = (count_reg == LAST_POS);
      active  = (count_reg < ACTIVE_END);
      hsync   = in_sync ? SYNC_POL : ~SYNC_POL;
   end

   assign count = count_reg;

endmodule

// File: tb/tb_vga_h_timing_counter.sv
`timescale 1ns/1ps

module tb_vga_h_timing_counter;

   localparam int H_TOTAL    = 1056;
   localparam int H_ACTIVE   = 800;
   localparam int SYNC_START = 840;
   localparam int SYNC_END   = 968;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] count;
   logic        eol;
   logic        active;
   logic        hsync;

   int n_total = 0;
   int n_pass  = 0;

   // Reference timeline: cyc is the index of the latest rising edge,
   // last_rst the index of the latest edge that saw rst=1 (0 = power-up).
   // The expected position is simply the number of edges since then, mod
   // the line length.
   longint cyc      = 0;
   longint last_rst = 0;
   longint last_eol = -1;

   always #12.5 clk = ~clk;

   vga_h_timing_counter dut (
      .clk    (clk),
      .rst    (rst),
      .count  (count),
      .eol    (eol),
      .active (active),
      .hsync  (hsync)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0d, expected %0d at t=%0t ns", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic int model_pos();
      return int'((cyc - last_rst) % H_TOTAL);
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (rst === 1'b1) last_rst = cyc;
   end

   // Per-cycle comparison against the reference position.
   always @(negedge clk) begin
      int m;
      m = model_pos();
      chk("count",  32'(count),  32'(m));
      chk("active", 32'(active), 32'(m < H_ACTIVE));
      chk("hsync",  32'(hsync),  32'(m >= SYNC_START && m < SYNC_END));
      chk("eol",    32'(eol),    32'(m == H_TOTAL - 1));
      if (eol === 1'b1) begin
         if (last_eol >= 0 && last_rst <= last_eol)
            chk("eol_period", 32'(cyc - last_eol), 32'(H_TOTAL));
         last_eol = cyc;
      end
   end

   task automatic wait_count(input int v);
      int k;
      k = 0;
      while (count !== 11'(v) && k < 1100) begin
         @(negedge clk);
         k++;
      end
      chk("wait_count", 32'(count), 32'(v));
   endtask

   initial begin
      int act_cnt;
      int hs_cnt;
      int gap;
      int len;

      // No clock edge during reset: outputs already defined at time 0.
      rst = 1'b1;
      #1;
      $display("power-up: count=%0d active=%0b hsync=%0b eol=%0b", count, active, hsync, eol);
      chk("t6_count",  32'(count),  32'd0);
      chk("t6_active", 32'(active), 32'd1);
      chk("t6_eol",    32'(eol),    32'd0);
      chk("t6_hsync",  32'(hsync),  32'd0);
      #9 rst = 1'b0;

      // First line after release: 1 after first edge, 1055 about 26.4 us in.
      @(negedge clk);
      chk("t1_first", 32'(count), 32'd1);
      repeat (1054) @(negedge clk);
      $display("line end: count=%0d eol=%0b t=%0t ns", count, eol, $time);
      chk("t1_last",  32'(count), 32'd1055);
      chk("t1_eol",   32'(eol),   32'd1);
      chk("t1_time",  32'($time > 26300 && $time < 26500), 32'd1);
      @(negedge clk);
      chk("t1_wrap",  32'(count), 32'd0);
      @(negedge clk);
      chk("t1_cont",  32'(count), 32'd1);

      // Decode widths over one full line, then free run.
      wait_count(0);
      act_cnt = 0;
      hs_cnt  = 0;
      repeat (H_TOTAL) begin
         if (active === 1'b1) act_cnt++;
         if (hsync  === 1'b1) hs_cnt++;
         @(negedge clk);
      end
      $display("line decode: active=%0d clocks hsync=%0d clocks", act_cnt, hs_cnt);
      chk("t3_active_len", 32'(act_cnt), 32'd800);
      chk("t3_hsync_len",  32'(hs_cnt),  32'd128);
      repeat (2 * H_TOTAL) @(negedge clk);

      // One-clock reset mid-line.
      wait_count(500);
      $display("reset pulse at count=%0d for 1 clock", count);
      rst = 1'b1;
      @(negedge clk);
      chk("t4_zero", 32'(count), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("t4_one",  32'(count), 32'd1);
      repeat (1054) @(negedge clk);
      chk("t4_eol",  32'(eol),   32'd1);

      // Reset held for five clocks starting at the last position.
      $display("reset hold at count=%0d for 5 clocks", count);
      rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("t5_hold_count", 32'(count), 32'd0);
         chk("t5_hold_eol",   32'(eol),   32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("t5_release", 32'(count), 32'd1);

      // Randomised reset pulses at random points in the line.
      for (int i = 0; i < 20; i++) begin
         gap = int'($urandom_range(1, 2500));
         len = int'($urandom_range(1, 4));
         repeat (gap) @(negedge clk);
         $display("random reset %0d: at count=%0d for %0d clocks", i, count, len);
         rst = 1'b1;
         repeat (len) @(negedge clk);
         rst = 1'b0;
      end
      repeat (H_TOTAL + 10) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
